// File: rtl/riscv_regfile.sv
// RV32I integer register file: one write port, two combinational read ports, x0 hardwired to zero.
// Optional same-cycle write-to-read bypass; o_rf_concat exposes stored state for debug/trace.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_regfile #(
  parameter int N_REG  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_rf_wen,
  input  logic [$clog2(N_REG)-1:0]   i_rf_rd_addr,
  input  logic [`XLEN-1:0]           i_rf_rd_data,
  input  logic [$clog2(N_REG)-1:0]   i_rf_rs1_addr,
  input  logic [$clog2(N_REG)-1:0]   i_rf_rs2_addr,
  output logic [`XLEN-1:0]           o_rf_rs1_data,
  output logic [`XLEN-1:0]           o_rf_rs2_data,
  output logic [N_REG*`XLEN-1:0]     o_rf_concat
);

  localparam int AW = $clog2(N_REG);
  localparam int XW = `XLEN;

  // Register 0 has no storage at all; only x1..x(N_REG-1) are flops.
  logic [N_REG-1:1] wen_onehot;
  logic [XW-1:0]    regs_q    [1:N_REG-1];
  logic [XW-1:0]    regs_d    [1:N_REG-1];
  logic [XW-1:0]    regs_view [N_REG];
  logic             rs1_hit;
  logic             rs2_hit;

  // Enable is qualified by wen first so an unknown rd address cannot leak into any enable.
  always_comb begin
    wen_onehot = '0;
    if (i_rf_wen) begin
      for (int k = 1; k < N_REG; k++) begin
        wen_onehot[k] = (i_rf_rd_addr == AW'(k));
      end
    end
  end

  always_comb begin
    for (int k = 1; k < N_REG; k++) begin
      regs_d[k] = wen_onehot[k] ? i_rf_rd_data : regs_q[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int k = 1; k < N_REG; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k < N_REG; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  always_comb begin
    regs_view[0] = '0;
    for (int k = 1; k < N_REG; k++) begin
      regs_view[k] = regs_q[k];
    end
  end

  always_comb begin
    o_rf_concat = '0;
    for (int k = 0; k < N_REG; k++) begin
      o_rf_concat[k*XW +: XW] = regs_view[k];
    end
  end

  // Bypass is suppressed during reset so outputs read zero while reset is held.
  assign rs1_hit = BYPASS && i_rstn && i_rf_wen &&
                   (i_rf_rs1_addr == i_rf_rd_addr) && (i_rf_rs1_addr != '0);
  assign rs2_hit = BYPASS && i_rstn && i_rf_wen &&
                   (i_rf_rs2_addr == i_rf_rd_addr) && (i_rf_rs2_addr != '0);

  always_comb begin
    o_rf_rs1_data = rs1_hit ? i_rf_rd_data : regs_view[i_rf_rs1_addr];
  end

  always_comb begin
    o_rf_rs2_data = rs2_hit ? i_rf_rd_data : regs_view[i_rf_rs2_addr];
  end

endmodule

// File: tb/tb_riscv_regfile.sv
// Bench for riscv_regfile: a 32-entry bypassing instance and a 16-entry non-bypassing
// instance, both checked against array reference models every cycle.
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_regfile;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          a_wen;
  logic [4:0]    a_rd, a_rs1, a_rs2;
  logic [31:0]   a_data, a_o1, a_o2;
  logic [1023:0] a_cat;

  logic          b_wen;
  logic [3:0]    b_rd, b_rs1, b_rs2;
  logic [31:0]   b_data, b_o1, b_o2;
  logic [511:0]  b_cat;

  logic [31:0] ma [32];
  logic [31:0] mb [16];

  int checks = 0;
  int failures = 0;

  riscv_regfile #(.N_REG(32), .BYPASS(1'b1)) u_rf32 (
    .i_clk(clk), .i_rstn(rstn), .i_rf_wen(a_wen), .i_rf_rd_addr(a_rd),
    .i_rf_rd_data(a_data), .i_rf_rs1_addr(a_rs1), .i_rf_rs2_addr(a_rs2),
    .o_rf_rs1_data(a_o1), .o_rf_rs2_data(a_o2), .o_rf_concat(a_cat));

  riscv_regfile #(.N_REG(16), .BYPASS(1'b0)) u_rf16 (
    .i_clk(clk), .i_rstn(rstn), .i_rf_wen(b_wen), .i_rf_rd_addr(b_rd),
    .i_rf_rd_data(b_data), .i_rf_rs1_addr(b_rs1), .i_rf_rs2_addr(b_rs2),
    .o_rf_rs1_data(b_o1), .o_rf_rs2_data(b_o2), .o_rf_concat(b_cat));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference reads: x0 is zero, reset forces zero, instance a forwards a same-cycle write.
  function automatic logic [31:0] exp_a(input logic [4:0] addr);
    if (!rstn || addr == 5'd0) return 32'h0;
    if (a_wen && a_rd == addr) return a_data;
    return ma[addr];
  endfunction

  function automatic logic [31:0] exp_b(input logic [3:0] addr);
    if (!rstn || addr == 4'd0) return 32'h0;
    return mb[addr];
  endfunction

  task automatic clear_models();
    for (int k = 0; k < 32; k++) ma[k] = 32'h0;
    for (int k = 0; k < 16; k++) mb[k] = 32'h0;
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_a_rs1"}, a_o1, exp_a(a_rs1));
    check({tag, "_a_rs2"}, a_o2, exp_a(a_rs2));
    check({tag, "_b_rs1"}, b_o1, exp_b(b_rs1));
    check({tag, "_b_rs2"}, b_o2, exp_b(b_rs2));
  endtask

  task automatic check_concat(input string tag);
    for (int k = 0; k < 32; k++) check($sformatf("%s_a_cat%0d", tag, k), a_cat[k*32 +: 32], ma[k]);
    for (int k = 0; k < 16; k++) check($sformatf("%s_b_cat%0d", tag, k), b_cat[k*32 +: 32], mb[k]);
  endtask

  // Called shortly after a falling edge with inputs already set; returns on the next falling edge.
  task automatic cycle(input string tag);
    #1;
    check_reads({tag, "_pre"});
    @(posedge clk);
    if (rstn) begin
      if (a_wen && a_rd != 5'd0) ma[a_rd] = a_data;
      if (b_wen && b_rd != 4'd0) mb[b_rd] = b_data;
    end
    #1;
    check_reads({tag, "_post"});
    check_concat(tag);
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    a_wen = 1'b0; a_rd = '0; a_rs1 = '0; a_rs2 = '0; a_data = '0;
    b_wen = 1'b0; b_rd = '0; b_rs1 = '0; b_rs2 = '0; b_data = '0;
    clear_models();
    #2;
    check_concat("rst_init");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Reset between edges clears a just-written register immediately.
    a_wen = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF; a_rs1 = 5'd5; a_rs2 = 5'd0;
    cycle("rst_wr");
    a_wen = 1'b0;
    #1;
    check("rst_x5_before", a_o1, 32'hDEADBEEF);
    rstn = 1'b0;
    clear_models();
    #1;
    check("rst_x5_async", a_o1, 32'h0);
    check_concat("rst_async");
    rstn = 1'b1;
    cycle("rst_rel");

    // Reset held across an edge with a write pending: write lost, no bypass while in reset.
    a_wen = 1'b1; a_rd = 5'd5; a_data = 32'h12345678; a_rs1 = 5'd5;
    rstn = 1'b0;
    #1;
    check("rst_mid_bypass", a_o1, 32'h0);
    @(posedge clk);
    #1;
    check("rst_mid_post", a_o1, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    a_wen = 1'b0;
    cycle("rst_mid_rel");
    check("rst_mid_x5", a_o1, 32'h0);

    // Sweep x1..x31 then cross-read every pair.
    for (int k = 1; k < 32; k++) begin
      a_wen = 1'b1; a_rd = 5'(k); a_data = 32'(k) * 32'h01010101;
      a_rs1 = 5'(k); a_rs2 = 5'(k - 1);
      cycle($sformatf("sweep_wr%0d", k));
    end
    a_wen = 1'b0;
    for (int k = 0; k < 32; k++) begin
      a_rs1 = 5'(k); a_rs2 = 5'(31 - k);
      #1;
      check($sformatf("sweep_rs1_%0d", k), a_o1, 32'(k) * 32'h01010101);
      check($sformatf("sweep_rs2_%0d", k), a_o2, 32'(31 - k) * 32'h01010101);
      cycle("sweep_rd");
    end

    // x0 write is discarded and disturbs nothing.
    a_wen = 1'b1; a_rd = 5'd0; a_data = 32'hFFFFFFFF; a_rs1 = 5'd0; a_rs2 = 5'd31;
    #1;
    check("x0_pre", a_o1, 32'h0);
    cycle("x0");
    check("x0_post", a_o1, 32'h0);
    check("x0_x31", a_cat[31*32 +: 32], 32'h1F1F1F1F);
    a_wen = 1'b0;

    // Bypass vs no-bypass on a write to x7 read by both ports in the same cycle.
    a_wen = 1'b1; a_rd = 5'd7; a_data = 32'h11111111;
    b_wen = 1'b1; b_rd = 4'd7; b_data = 32'h11111111;
    cycle("byp_setup");
    a_data = 32'h22222222; a_rs1 = 5'd7; a_rs2 = 5'd7;
    b_data = 32'h22222222; b_rs1 = 4'd7; b_rs2 = 4'd7;
    #1;
    check("byp_a_rs1_pre", a_o1, 32'h22222222);
    check("byp_a_rs2_pre", a_o2, 32'h22222222);
    check("byp_b_rs1_pre", b_o1, 32'h11111111);
    check("byp_b_rs2_pre", b_o2, 32'h11111111);
    cycle("byp");
    check("byp_b_rs1_post", b_o1, 32'h22222222);
    check("byp_b_rs2_post", b_o2, 32'h22222222);
    a_wen = 1'b0; b_wen = 1'b0;

    // Write disable holds x9 at its swept value, including with an undriven rd address.
    a_rd = 5'd9; a_data = 32'hCAFEF00D; a_rs1 = 5'd9; a_rs2 = 5'd9;
    for (int i = 0; i < 5; i++) cycle("wdis");
    a_rd = 'x;
    cycle("wdis_x");
    a_rd = 5'd9;
    check("wdis_x9", a_o1, 32'h09090909);

    // Randomized traffic on both instances.
    for (int i = 0; i < 1000; i++) begin
      a_wen = 1'($urandom); a_rd = 5'($urandom); a_data = $urandom;
      a_rs1 = 5'($urandom); a_rs2 = 5'($urandom);
      if ($urandom_range(3) == 0) a_rs1 = a_rd;
      b_wen = 1'($urandom); b_rd = 4'($urandom); b_data = $urandom;
      b_rs1 = 4'($urandom); b_rs2 = 4'($urandom);
      if ($urandom_range(3) == 0) b_rs2 = b_rd;
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
